// File: rtl/color_rx_pkg.sv
// Shared types and constants for the colour-sensor I2C read-data stage.
package color_rx_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        ACK   = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int NUM_BYTES     = 8;
    localparam int BITS_PER_BYTE = 8;

    localparam int CH_CLEAR = 0;
    localparam int CH_RED   = 1;
    localparam int CH_GREEN = 2;
    localparam int CH_BLUE  = 3;

    // States in which the bus is expected to keep clocking.
    function automatic logic is_active(input state_t s);
        return (s == SHIFT) || (s == ACK);
    endfunction

endpackage

// File: rtl/i2c_sync_edge.sv
// Multi-flop synchronizer for one asynchronous bus line, with rise/fall pulses.
module i2c_sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    // Idle bus lines are pulled high, so reset to that level to avoid a false edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= {STAGES{RST_VAL}};
            prev_q <= RST_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/i2c_color_rx.sv
// Read-data stage: shifts in eight bytes from SCL/SDA and publishes four 16-bit colour channels.
module i2c_color_rx
    import color_rx_pkg::*;
#(
    parameter int TIMEOUT_CYC = 16384,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        scl_in,
    input  logic        sda_in,
    input  logic        start,
    output logic        ack_drive,
    output logic        ack_val,
    output logic        busy,
    output logic [15:0] clear_data,
    output logic [15:0] red_data,
    output logic [15:0] green_data,
    output logic [15:0] blue_data,
    output logic        data_valid,
    output logic        timeout_err
);

    localparam int               TMO_W     = $clog2(TIMEOUT_CYC);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       BIT_FULL  = 4'(BITS_PER_BYTE);
    localparam logic [2:0]       LAST_BYTE = 3'(NUM_BYTES - 1);

    logic scl_rise, scl_fall, scl_level_unused;
    logic sda_s, sda_rise_unused, sda_fall_unused;

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_scl_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (scl_in),
        .level (scl_level_unused),
        .rise  (scl_rise),
        .fall  (scl_fall)
    );

    i2c_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sda_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (sda_in),
        .level (sda_s),
        .rise  (sda_rise_unused),
        .fall  (sda_fall_unused)
    );

    state_t           state_q, state_d;
    logic [3:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]       byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic [7:0]       shift_q, shift_d;
    logic             buf_we;
    logic             timeout_d;
    logic [7:0]       byte_buf [NUM_BYTES];

    // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        byte_cnt_d = byte_cnt_q;
        tmo_d      = tmo_q;
        shift_d    = shift_q;
        buf_we     = 1'b0;
        timeout_d  = 1'b0;

        if (is_active(state_q)) begin
            tmo_d = (scl_rise || scl_fall) ? '0 : tmo_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    tmo_d      = '0;
                    state_d    = SHIFT;
                end
            end
            SHIFT: begin
                if (scl_rise && (bit_cnt_q < BIT_FULL)) begin
                    shift_d   = {shift_q[6:0], sda_s};
                    bit_cnt_d = bit_cnt_q + 1'b1;
                end else if (scl_fall && (bit_cnt_q == BIT_FULL)) begin
                    buf_we    = 1'b1;
                    bit_cnt_d = '0;
                    state_d   = ACK;
                end
            end
            ACK: begin
                // The 9th SCL rise is the slave sampling our ACK; only its fall matters.
                if (scl_fall) begin
                    if (byte_cnt_q == LAST_BYTE) begin
                        state_d = DONE;
                    end else begin
                        byte_cnt_d = byte_cnt_q + 1'b1;
                        state_d    = SHIFT;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        if (is_active(state_q) && !(scl_rise || scl_fall) && (tmo_q == TMO_LAST)) begin
            timeout_d = 1'b1;
            state_d   = IDLE;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            byte_cnt_q  <= '0;
            tmo_q       <= '0;
            shift_q     <= '0;
            data_valid  <= 1'b0;
            timeout_err <= 1'b0;
            clear_data  <= '0;
            red_data    <= '0;
            green_data  <= '0;
            blue_data   <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            byte_cnt_q  <= byte_cnt_d;
            tmo_q       <= tmo_d;
            shift_q     <= shift_d;
            data_valid  <= (state_q == DONE);
            timeout_err <= timeout_d;
            if (state_q == DONE) begin
                clear_data <= {byte_buf[2*CH_CLEAR+1], byte_buf[2*CH_CLEAR]};
                red_data   <= {byte_buf[2*CH_RED+1],   byte_buf[2*CH_RED]};
                green_data <= {byte_buf[2*CH_GREEN+1], byte_buf[2*CH_GREEN]};
                blue_data  <= {byte_buf[2*CH_BLUE+1],  byte_buf[2*CH_BLUE]};
            end
        end
    end

    // NOTE: the byte buffer has no reset; it is always fully rewritten before DONE reads it.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            byte_buf[byte_cnt_q] <= shift_q;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ack_drive = (state_q == ACK);
    assign ack_val   = (state_q != ACK) || (byte_cnt_q == LAST_BYTE);

endmodule

// File: tb/tb_i2c_color_rx.sv
// Self-checking bench: bus model clocks bytes in, results compared to a channel model.
`timescale 1ns/1ps
module tb_i2c_color_rx;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl = 1'b1;
    logic sda = 1'b1;
    logic start = 1'b0;
    logic start_t = 1'b0;

    logic        ack_drive, ack_val, busy, data_valid, timeout_err;
    logic [15:0] clear_data, red_data, green_data, blue_data;
    logic        ack_drive_t, ack_val_t, busy_t, data_valid_t, timeout_err_t;
    logic [15:0] clear_data_t, red_data_t, green_data_t, blue_data_t;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always #10 clk = ~clk;  // 50 MHz

    i2c_color_rx dut (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda), .start(start),
        .ack_drive(ack_drive), .ack_val(ack_val), .busy(busy),
        .clear_data(clear_data), .red_data(red_data), .green_data(green_data), .blue_data(blue_data),
        .data_valid(data_valid), .timeout_err(timeout_err)
    );

    i2c_color_rx #(.TIMEOUT_CYC(64)) dut_t (
        .clk(clk), .rst(rst), .scl_in(scl), .sda_in(sda), .start(start_t),
        .ack_drive(ack_drive_t), .ack_val(ack_val_t), .busy(busy_t),
        .clear_data(clear_data_t), .red_data(red_data_t), .green_data(green_data_t), .blue_data(blue_data_t),
        .data_valid(data_valid_t), .timeout_err(timeout_err_t)
    );

    logic [1:0]  ad_w, av_w, busy_w, dv_w, te_w;
    logic [15:0] ch_o [2][4];
    assign ad_w   = {ack_drive_t, ack_drive};
    assign av_w   = {ack_val_t, ack_val};
    assign busy_w = {busy_t, busy};
    assign dv_w   = {data_valid_t, data_valid};
    assign te_w   = {timeout_err_t, timeout_err};
    assign ch_o[0][0] = clear_data;   assign ch_o[0][1] = red_data;
    assign ch_o[0][2] = green_data;   assign ch_o[0][3] = blue_data;
    assign ch_o[1][0] = clear_data_t; assign ch_o[1][1] = red_data_t;
    assign ch_o[1][2] = green_data_t; assign ch_o[1][3] = blue_data_t;

    // Event counters per DUT (index 0 = default, 1 = short timeout)
    int ack_slots [2] = '{0, 0};
    int dv_pulses [2] = '{0, 0};
    int dv_cycles [2] = '{0, 0};
    int tmo_cycles[2] = '{0, 0};
    int tmo_last  [2] = '{0, 0};
    logic [1:0] ad_prev = '0;
    logic [1:0] dv_prev = '0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (ad_w[s] && !ad_prev[s]) ack_slots[s] <= ack_slots[s] + 1;
            if (dv_w[s]) dv_cycles[s] <= dv_cycles[s] + 1;
            if (dv_w[s] && !dv_prev[s]) dv_pulses[s] <= dv_pulses[s] + 1;
            if (te_w[s]) begin
                tmo_cycles[s] <= tmo_cycles[s] + 1;
                tmo_last[s]   <= cyc;
            end
        end
        ad_prev <= ad_w;
        dv_prev <= dv_w;
    end

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "watchdog");
    end

    // Reference model: channel k is little-endian word from bytes 2k (low) and 2k+1 (high).
    function automatic int exp_ch(input logic [7:0] b [8], input int k);
        return int'(b[2*k]) + 256 * int'(b[2*k+1]);
    endfunction

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic begin_xfer(input int sel, input int hp);
        scl = 1'b0;
        sda = 1'b1;
        wait_clk(hp / 2);
        if (sel == 1) start_t = 1'b1; else start = 1'b1;
        wait_clk(1);
        start   = 1'b0;
        start_t = 1'b0;
    endtask

    task automatic end_xfer(input int hp);
        wait_clk(hp / 2); sda = 1'b0;
        wait_clk(hp / 2); scl = 1'b1;
        wait_clk(hp / 2); sda = 1'b1;
        wait_clk(10);
    endtask

    // One byte MSB first plus the ACK clock; checks ack_drive/ack_val on the way.
    task automatic xfer_byte(input logic [7:0] b, input int hp, input int sel,
                             input bit last, input bit glitch, input bit poke);
        for (int i = 7; i >= 0; i--) begin
            wait_clk(hp / 2); sda = b[i];
            wait_clk(hp / 2); scl = 1'b1;
            wait_clk(hp / 2);
            checks++;
            if (ad_w[sel] !== 1'b0) begin
                errors++;
                $display("FAIL ack_drive_data dut%0d bit%0d: got %b expected 0", sel, i, ad_w[sel]);
            end
            if (glitch && i == 4) begin
                sda = ~b[i]; wait_clk(2); sda = b[i];
            end
            if (poke && i == 3) begin
                start = 1'b1; wait_clk(1); start = 1'b0;
            end
            wait_clk(hp / 2); scl = 1'b0;
        end
        wait_clk(hp / 2); sda = 1'b1;
        wait_clk(hp / 2); scl = 1'b1;
        wait_clk(hp / 2);
        checks++;
        if (ad_w[sel] !== 1'b1) begin
            errors++;
            $display("FAIL ack_drive_slot dut%0d: got %b expected 1", sel, ad_w[sel]);
        end
        checks++;
        if (av_w[sel] !== last) begin
            errors++;
            $display("FAIL ack_val_slot dut%0d: got %b expected %b", sel, av_w[sel], last);
        end
        wait_clk(hp / 2); scl = 1'b0;
    endtask

    task automatic full_xfer(input logic [7:0] b [8], input int hp, input int sel,
                             input int glitch_byte, input int poke_byte, input string tag);
        int dvp0 = dv_pulses[sel];
        int dvc0 = dv_cycles[sel];
        int as0  = ack_slots[sel];
        begin_xfer(sel, hp);
        for (int n = 0; n < 8; n++)
            xfer_byte(b[n], hp, sel, n == 7, n == glitch_byte, n == poke_byte);
        end_xfer(hp);
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ch_o[sel][k] !== 16'(exp_ch(b, k))) begin
                errors++;
                $display("FAIL %s ch%0d: got %h expected %h", tag, k, ch_o[sel][k], 16'(exp_ch(b, k)));
            end
        end
        checks++;
        if (dv_pulses[sel] - dvp0 !== 1) begin
            errors++;
            $display("FAIL %s dv_pulses: got %0d expected 1", tag, dv_pulses[sel] - dvp0);
        end
        checks++;
        if (dv_cycles[sel] - dvc0 !== 1) begin
            errors++;
            $display("FAIL %s dv_cycles: got %0d expected 1", tag, dv_cycles[sel] - dvc0);
        end
        checks++;
        if (ack_slots[sel] - as0 !== 8) begin
            errors++;
            $display("FAIL %s ack_slots: got %0d expected 8", tag, ack_slots[sel] - as0);
        end
        checks++;
        if (busy_w[sel] !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after: got %b expected 0", tag, busy_w[sel]);
        end
    endtask

    task automatic rand_bytes(output logic [7:0] b [8]);
        for (int i = 0; i < 8; i++) b[i] = 8'($urandom);
    endtask

    task automatic check_reset_outputs(input string tag);
        checks++;
        if ({ack_drive, ack_val, busy, data_valid, timeout_err} !== 5'b01000) begin
            errors++;
            $display("FAIL %s ctrl: got %b expected 01000", tag,
                     {ack_drive, ack_val, busy, data_valid, timeout_err});
        end
        checks++;
        if ({clear_data, red_data, green_data, blue_data} !== 64'h0) begin
            errors++;
            $display("FAIL %s channels: got %h expected 0", tag,
                     {clear_data, red_data, green_data, blue_data});
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        wait_clk(5);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clk(5);
    endtask

    task automatic test_happy();
        logic [7:0] b [8];
        b = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A, 8'hF0, 8'hDE};
        full_xfer(b, 250, 0, -1, -1, "happy");  // 100 kHz SCL
    endtask

    task automatic test_random();
        logic [7:0] b [8];
        for (int r = 0; r < 2; r++) begin
            rand_bytes(b);
            full_xfer(b, 20, 0, -1, -1, "random");
        end
    endtask

    task automatic test_timeout();
        logic [7:0] b [8];
        logic [15:0] prev [4];
        int dvp0, tmo0, t0, waited;
        rand_bytes(b);
        full_xfer(b, 20, 1, -1, -1, "tmo_pre");
        for (int k = 0; k < 4; k++) prev[k] = ch_o[1][k];
        dvp0 = dv_pulses[1];
        tmo0 = tmo_cycles[1];
        rand_bytes(b);
        begin_xfer(1, 20);
        for (int n = 0; n < 3; n++) xfer_byte(b[n], 20, 1, 1'b0, 1'b0, 1'b0);
        wait_clk(10); sda = 1'b0;
        wait_clk(10); scl = 1'b1;
        t0 = cyc;
        waited = 0;
        while (tmo_cycles[1] == tmo0 && waited < 500) begin
            wait_clk(1);
            waited++;
        end
        checks++;
        if (tmo_cycles[1] == tmo0) begin
            errors++;
            $display("FAIL tmo_fired: got no pulse expected one within 500 cycles");
        end else begin
            checks++;
            if (tmo_last[1] - t0 < 64 || tmo_last[1] - t0 > 70) begin
                errors++;
                $display("FAIL tmo_delay: got %0d cycles expected 64..70", tmo_last[1] - t0);
            end
        end
        wait_clk(5);
        checks++;
        if (tmo_cycles[1] - tmo0 !== 1) begin
            errors++;
            $display("FAIL tmo_width: got %0d cycles expected 1", tmo_cycles[1] - tmo0);
        end
        checks++;
        if (busy_t !== 1'b0) begin
            errors++;
            $display("FAIL tmo_busy: got %b expected 0", busy_t);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (ch_o[1][k] !== prev[k]) begin
                errors++;
                $display("FAIL tmo_hold ch%0d: got %h expected %h", k, ch_o[1][k], prev[k]);
            end
        end
        checks++;
        if (dv_pulses[1] !== dvp0) begin
            errors++;
            $display("FAIL tmo_no_dv: got %0d pulses expected %0d", dv_pulses[1], dvp0);
        end
        sda = 1'b1;
        wait_clk(10);
    endtask

    task automatic test_reset_mid();
        logic [7:0] b [8];
        int dvp0;
        rand_bytes(b);
        dvp0 = dv_pulses[0];
        begin_xfer(0, 20);
        for (int n = 0; n < 4; n++) xfer_byte(b[n], 20, 0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            wait_clk(10); sda = b[4][7-i];
            wait_clk(10); scl = 1'b1;
            wait_clk(10); scl = 1'b0;
        end
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_busy_before: got %b expected 1", busy);
        end
        rst = 1'b1;
        #1;
        check_reset_outputs("rstmid_async");
        wait_clk(3);
        rst = 1'b0;
        scl = 1'b1;
        sda = 1'b1;
        wait_clk(10);
        checks++;
        if (dv_pulses[0] !== dvp0) begin
            errors++;
            $display("FAIL rstmid_no_dv: got %0d pulses expected %0d", dv_pulses[0], dvp0);
        end
        rand_bytes(b);
        full_xfer(b, 20, 0, -1, -1, "rstmid_after");
    endtask

    task automatic test_start_busy();
        logic [7:0] b [8];
        rand_bytes(b);
        full_xfer(b, 20, 0, -1, 2, "start_busy");
    endtask

    task automatic test_sda_glitch();
        logic [7:0] b [8];
        rand_bytes(b);
        full_xfer(b, 20, 0, 1, -1, "sda_glitch");
    endtask

    initial begin
        test_reset();
        test_happy();
        test_random();
        test_timeout();
        test_reset_mid();
        test_start_busy();
        test_sda_glitch();
        checks++;
        if (tmo_cycles[0] !== 0) begin
            errors++;
            $display("FAIL default_no_timeout: got %0d cycles expected 0", tmo_cycles[0]);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
